// File: rtl/mobo_bus_ctrl.sv
// mobo_bus_ctrl: bridges one CPU ctrl/stat bus request to one of NUM_DEV
// device channels. Each channel owns a 2^REGION_BITS window above BASE_ADDR.
// The controller runs the device request/done/release handshake and has a
// per-transaction timeout on DONE. Malformed requests are rejected with ERR.
module mobo_bus_ctrl #(
  parameter int unsigned           WORD_WIDTH  = 32,
  parameter int unsigned           NUM_DEV     = 2,
  parameter logic [WORD_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           REGION_BITS = 16,
  parameter int unsigned           TIMEOUT     = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_WIDTH-1:0]         cpu_ctrl,
  output logic [WORD_WIDTH-1:0]         cpu_stat,
  input  logic [WORD_WIDTH-1:0]         cpu_addr,
  input  logic [WORD_WIDTH-1:0]         cpu_wdata,
  output logic [WORD_WIDTH-1:0]         cpu_rdata,
  output logic [NUM_DEV*WORD_WIDTH-1:0] dev_ctrl,
  input  logic [NUM_DEV*WORD_WIDTH-1:0] dev_stat,
  output logic [WORD_WIDTH-1:0]         addr,
  output logic [WORD_WIDTH-1:0]         data_out,
  input  logic [NUM_DEV*WORD_WIDTH-1:0] data_in
);

  localparam int unsigned IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [1:0]                    op_q, op_d;
  logic [WORD_WIDTH-1:0]         addr_q, addr_d;
  logic [WORD_WIDTH-1:0]         wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]         stat_q, stat_d;
  logic [WORD_WIDTH-1:0]         rdata_q, rdata_d;
  logic [NUM_DEV*WORD_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [31:0]                   cnt_q, cnt_d;

  // Address decode (combinational from the live CPU address)
  logic [WORD_WIDTH-1:0] dec_off;
  logic [WORD_WIDTH-1:0] dec_region;
  logic [WORD_WIDTH-1:0] dec_addr;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_invalid;

  assign dec_off     = cpu_addr - BASE_ADDR;
  assign dec_region  = dec_off >> REGION_BITS;
  assign dec_idx     = dec_region[IDX_W-1:0];
  assign dec_invalid = (cpu_addr < BASE_ADDR) || (dec_region >= WORD_WIDTH'(NUM_DEV));
  assign dec_addr    = dec_off & ((WORD_WIDTH'(1) << REGION_BITS) - WORD_WIDTH'(1));

  // Build a ctrl vector with only the selected channel driven.
  function automatic logic [NUM_DEV*WORD_WIDTH-1:0] ctrl_slice(
    input logic [IDX_W-1:0] sel,
    input logic [1:0]       op
  );
    logic [NUM_DEV*WORD_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < int'(NUM_DEV); j++) begin
      if (sel == IDX_W'(j)) r[j*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(op);
    end
    return r;
  endfunction

  logic [WORD_WIDTH-1:0] sel_stat;
  logic [WORD_WIDTH-1:0] sel_data;

  // Mux the latched channel's status and read data
  always_comb begin
    sel_stat = '0;
    sel_data = '0;
    for (int j = 0; j < int'(NUM_DEV); j++) begin
      if (idx_q == IDX_W'(j)) begin
        sel_stat = dev_stat[j*WORD_WIDTH +: WORD_WIDTH];
        sel_data = data_in[j*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    stat_d  = stat_q;
    rdata_d = rdata_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_ctrl[1:0] != 2'b00) begin
          if ((cpu_ctrl[1:0] == 2'b11) || dec_invalid) begin
            stat_d  = WORD_WIDTH'(3);
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = dec_idx;
            op_d    = cpu_ctrl[1:0];
            addr_d  = dec_addr;
            wdata_d = cpu_wdata;
            rdata_d = '0;
            cnt_d   = '0;
            ctrl_d  = ctrl_slice(dec_idx, cpu_ctrl[1:0]);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (sel_stat[0]) begin
          if (op_q == 2'b01) rdata_d = sel_data;
          ctrl_d  = '0;
          state_d = S_RELEASE;
        end else if ((TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1))) begin
          ctrl_d  = '0;
          stat_d  = WORD_WIDTH'(7);
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RELEASE: begin
        // No timeout here: a device that never releases stalls the bus.
        if (sel_stat == '0) begin
          stat_d  = WORD_WIDTH'(1);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (cpu_ctrl == '0) begin
          stat_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops device requests immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      stat_q  <= stat_d;
      rdata_q <= rdata_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_stat  = stat_q;
  assign cpu_rdata = rdata_q;
  assign dev_ctrl  = ctrl_q;
  assign addr      = addr_q;
  assign data_out  = wdata_q;

endmodule

// File: tb/tb_mobo_bus_ctrl.sv
// Scoreboard bench for mobo_bus_ctrl with two behavioural device channels.
module tb_mobo_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_ctrl = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_stat;
  logic [31:0] cpu_rdata;
  logic [63:0] dev_ctrl;
  logic [63:0] dev_stat;
  logic [31:0] addr;
  logic [31:0] data_out;
  logic [63:0] data_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] stat;
    logic [31:0] rdata;
    bit          chk_rd;
  } exp_t;
  exp_t sb[$];

  mobo_bus_ctrl #(
    .WORD_WIDTH(32), .NUM_DEV(2), .BASE_ADDR(32'h0), .REGION_BITS(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_ctrl(cpu_ctrl), .cpu_stat(cpu_stat), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dev_ctrl(dev_ctrl), .dev_stat(dev_stat),
    .addr(addr), .data_out(data_out), .data_in(data_in)
  );

  always #5 clk = ~clk;

  // Behavioural devices: DONE after done_dly cycles, release rel_hold cycles after ctrl drops
  logic [31:0] dstat[2];
  logic [31:0] ddata[2];
  int          wcnt[2];
  int          hcnt[2];
  int          done_dly[2];
  int          rel_hold[2];
  bit          never_done[2];
  logic [31:0] rd_val[2];

  assign dev_stat = {dstat[1], dstat[0]};
  assign data_in  = {ddata[1], ddata[0]};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        dstat[i] <= '0;
        ddata[i] <= '0;
        wcnt[i] = 0;
        hcnt[i] = 0;
      end else if (dev_ctrl[i*32 +: 32] != 32'h0) begin
        hcnt[i] = 0;
        if (!never_done[i] && dstat[i] == 32'h0) begin
          if (wcnt[i] >= done_dly[i]) begin
            dstat[i] <= 32'h1;
            ddata[i] <= rd_val[i];
            wcnt[i] = 0;
          end else begin
            wcnt[i]++;
          end
        end
      end else begin
        wcnt[i] = 0;
        if (dstat[i] != 32'h0) begin
          if (hcnt[i] >= rel_hold[i]) begin
            dstat[i] <= '0;
            hcnt[i] = 0;
          end else begin
            hcnt[i]++;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop an expectation whenever the CPU status goes nonzero
  logic [31:0] prev_stat = '0;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_stat != 32'h0 && prev_stat == 32'h0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got stat %0h expected no response", cpu_stat);
        end else begin
          e = sb.pop_front();
          chk("rsp_stat", {32'h0, cpu_stat}, {32'h0, e.stat});
          if (e.chk_rd) chk("rsp_rdata", {32'h0, cpu_rdata}, {32'h0, e.rdata});
        end
      end
      prev_stat = cpu_stat;
    end else begin
      prev_stat = '0;
    end
  end

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!cpu_stat[0] && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!cpu_stat[0]) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no DONE expected DONE within %0d cycles", budget);
    end
  endtask

  task automatic finish_txn();
    cpu_ctrl = '0;
    @(negedge clk);
    chk("stat_cleared", {32'h0, cpu_stat}, 64'h0);
  endtask

  task automatic drive(input logic [31:0] c, input logic [31:0] a, input logic [31:0] w);
    cpu_ctrl  = c;
    cpu_addr  = a;
    cpu_wdata = w;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      done_dly[i] = 0; rel_hold[i] = 0; never_done[i] = 0; rd_val[i] = '0;
    end
    #1;
    chk("rst_stat", {32'h0, cpu_stat}, 64'h0);
    chk("rst_devctrl", dev_ctrl, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write to dev1 offset 4, zero-wait device
    sb.push_back('{32'h1, 32'h0, 1'b0});
    drive(32'h2, 32'h0001_0004, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_devctrl1", {32'h0, dev_ctrl[63:32]}, 64'h2);
    chk("wr_devctrl0", {32'h0, dev_ctrl[31:0]}, 64'h0);
    chk("wr_addr", {32'h0, addr}, 64'h4);
    chk("wr_data_out", {32'h0, data_out}, 64'hDEAD_BEEF);
    wait_done(20, lat);
    chk("wr_latency", 64'(lat + 1), 64'd5);
    @(negedge clk);
    chk("wr_stat_held", {32'h0, cpu_stat}, 64'h1);
    finish_txn();

    // Read from dev0 offset 0x10
    rd_val[0] = 32'h1234_5678;
    sb.push_back('{32'h1, 32'h1234_5678, 1'b1});
    drive(32'h1, 32'h0000_0010, 32'h0);
    @(negedge clk);
    chk("rd_devctrl0_on", {32'h0, dev_ctrl[31:0]}, 64'h1);
    chk("rd_addr", {32'h0, addr}, 64'h10);
    @(negedge clk);
    chk("rd_devctrl0_held", {32'h0, dev_ctrl[31:0]}, 64'h1);
    @(negedge clk);
    chk("rd_devctrl0_off", {32'h0, dev_ctrl[31:0]}, 64'h0);
    wait_done(20, lat);
    finish_txn();

    // Out-of-map address
    sb.push_back('{32'h3, 32'h0, 1'b1});
    drive(32'h1, 32'h0002_0000, 32'h0);
    @(negedge clk);
    chk("badaddr_devctrl", dev_ctrl, 64'h0);
    chk("badaddr_stat", {32'h0, cpu_stat}, 64'h3);
    finish_txn();

    // READ and WRITE together to a valid address
    sb.push_back('{32'h3, 32'h0, 1'b1});
    drive(32'h3, 32'h0000_0020, 32'h0);
    @(negedge clk);
    chk("rdwr_devctrl", dev_ctrl, 64'h0);
    finish_txn();

    // Timeout: dev1 never answers
    never_done[1] = 1'b1;
    sb.push_back('{32'h7, 32'h0, 1'b1});
    drive(32'h1, 32'h0001_0000, 32'h0);
    repeat (8) @(negedge clk);
    chk("to_devctrl1_last", {32'h0, dev_ctrl[63:32]}, 64'h1);
    @(negedge clk);
    chk("to_devctrl1_drop", {32'h0, dev_ctrl[63:32]}, 64'h0);
    chk("to_stat", {32'h0, cpu_stat}, 64'h7);
    finish_txn();
    never_done[1] = 1'b0;

    // Slow release on dev0: DONE only after the device goes idle
    rel_hold[0] = 5;
    sb.push_back('{32'h1, 32'h0, 1'b0});
    drive(32'h2, 32'h0000_0010, 32'h5555_AAAA);
    wait_done(40, lat);
    chk("slowrel_latency", 64'(lat), 64'd10);
    finish_txn();
    rel_hold[0] = 0;

    // Asynchronous reset in the middle of WAIT
    never_done[1] = 1'b1;
    drive(32'h1, 32'h0001_0000, 32'h0);
    repeat (3) @(negedge clk);
    chk("rstw_devctrl_before", {32'h0, dev_ctrl[63:32]}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_devctrl", dev_ctrl, 64'h0);
    chk("rstw_stat", {32'h0, cpu_stat}, 64'h0);
    cpu_ctrl = '0;
    @(negedge clk);
    rst = 1'b0;
    never_done[1] = 1'b0;
    rd_val[1] = 32'hCAFE_F00D;
    @(negedge clk);
    sb.push_back('{32'h1, 32'hCAFE_F00D, 1'b1});
    drive(32'h1, 32'h0001_0008, 32'h0);
    wait_done(20, lat);
    chk("post_rst_latency", 64'(lat), 64'd5);
    finish_txn();

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mobo_bus_ctrl.md
Name: mobo_bus_ctrl

Overview:
Parametrised successor to the board-level bus controller. It takes one CPU ctrl/stat bus request and decodes the address to one of NUM_DEV device channels, with no fixed RAM/VGA split. It runs the full request/done/release handshake with that device and returns data and status to the CPU. New over the previous generation: N channels, a base-plus-region address map, a per-transaction timeout, rejection of illegal requests, and error/timeout status bits.

Parameters:
WORD_WIDTH, 32, width of address, data, ctrl and stat words
NUM_DEV, 2, number of device channels (1..16)
BASE_ADDR, 0, first CPU address of the device map
REGION_BITS, 16, log2 of the region size per device; device i owns [BASE_ADDR + i<<REGION_BITS, +2^REGION_BITS)
TIMEOUT, 1024, maximum cycles spent waiting for device DONE; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_ctrl  in  WORD_WIDTH  CPU request: bit0 READ, bit1 WRITE, other bits ignored
cpu_stat  out  WORD_WIDTH  bit0 DONE, bit1 ERR, bit2 TIMEOUT, others 0
cpu_addr  in  WORD_WIDTH  CPU address
cpu_wdata  in  WORD_WIDTH  CPU write data
cpu_rdata  out  WORD_WIDTH  read data, valid while cpu_stat.DONE=1
dev_ctrl  out  NUM_DEV*WORD_WIDTH  per-device ctrl; channel i is slice i (bit0 READ, bit1 WRITE)
dev_stat  in  NUM_DEV*WORD_WIDTH  per-device stat; bit0 DONE, all-zero means idle
addr  out  WORD_WIDTH  shared device address: offset within the region
data_out  out  WORD_WIDTH  shared write data to devices
data_in  in  NUM_DEV*WORD_WIDTH  per-device read data

Behaviour:
- All outputs are registered. Reset (async, rst=1) forces state IDLE; cpu_stat, cpu_rdata, dev_ctrl, addr and data_out to 0; timeout counter to 0. Reset mid-transaction drops dev_ctrl immediately and does not wait for device release.
- Decode is combinational from cpu_addr:
  - off = cpu_addr - BASE_ADDR (WORD_WIDTH bits, modulo).
  - idx = off >> REGION_BITS.
  - Invalid if cpu_addr < BASE_ADDR or idx >= NUM_DEV.
  - Device address = off & (2^REGION_BITS - 1).
- IDLE:
  - If cpu_ctrl[1:0]==0, stay in IDLE.
  - If cpu_ctrl[1:0]==2'b11 or the address is invalid, go to DONE with ERR=1, cpu_rdata=0 and no device access.
  - Otherwise latch idx, the operation, addr and data_out (=cpu_wdata), and go to WAIT. dev_ctrl[idx] = READ or WRITE becomes visible the cycle after the request is sampled.
- WAIT:
  - Hold dev_ctrl[idx]; the counter increments each cycle.
  - When dev_stat[idx].DONE=1 is sampled: for READ, latch cpu_rdata = data_in[idx]; then clear dev_ctrl[idx] and go to RELEASE.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without DONE: clear dev_ctrl, go to DONE with ERR=1, TIMEOUT=1, cpu_rdata=0.
- RELEASE: wait until dev_stat[idx]==0, then go to DONE with cpu_stat.DONE=1 (ERR=0). There is no timeout in RELEASE.
- DONE:
  - cpu_stat is held, with DONE=1 plus any error bits, while cpu_ctrl != 0.
  - When cpu_ctrl==0 is sampled: cpu_stat=0, then IDLE. A new request can be sampled one cycle later.
  - cpu_addr, cpu_wdata and cpu_ctrl changes during WAIT or RELEASE are ignored; latched values are used.
- Only one dev_ctrl slice is nonzero at any time. Non-selected slices stay 0.
- The counter clears on entry to WAIT.
- Minimum latency for a zero-wait device (DONE the cycle after ctrl, idle the cycle after ctrl drops): cpu_stat.DONE is visible 4 cycles after the request is sampled.

Test Plan:
All scenarios use NUM_DEV=2, BASE_ADDR=0, REGION_BITS=16, TIMEOUT=8.
- Write path: cpu_ctrl=2, cpu_addr=0x0001_0004, cpu_wdata=0xDEADBEEF -> dev_ctrl slice1=2, slice0=0, addr=0x4, data_out=0xDEADBEEF; after dev1 DONE then idle, cpu_stat=0x1; after cpu_ctrl=0, cpu_stat=0.
- Read path: cpu_ctrl=1, addr 0x0000_0010, dev0 returns data_in=0x1234_5678 with DONE -> cpu_rdata=0x12345678, cpu_stat=0x1, dev_ctrl0 cleared the cycle after DONE is sampled.
- Bad requests: cpu_addr=0x0002_0000 -> cpu_stat=0x3 with no dev_ctrl activity; cpu_ctrl=3 to a valid address -> cpu_stat=0x3.
- Timeout: dev1 never asserts DONE -> dev_ctrl1 drops after 8 WAIT cycles, cpu_stat=0x7, cpu_rdata=0.
- Slow release: dev0 holds DONE for 5 cycles after ctrl drops -> cpu_stat stays 0 until dev_stat0==0, then 0x1.
- Reset mid-WAIT: assert rst asynchronously -> dev_ctrl=0 and cpu_stat=0 immediately; after rst falls, the next request completes normally.
